trap_event_gen: RTL
===================

TRAP_EVENT_GEN -- requirements
Module: trap_event_gen

Interface
REQ-001 SHALL have parameter COREID, default 0, 8-bit hart id reported on io_coreid.
REQ-002 SHALL have parameter COMMIT_W, default 2, commit slots per cycle (legal 1..4).
REQ-003 SHALL have port clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port io_commit_valid  in  COMMIT_W  per-slot instruction retired this cycle; slot 0 oldest.
REQ-006 SHALL have port io_commit_is_trap  in  COMMIT_W  per-slot retired instruction is the simulation-halt trap.
REQ-007 SHALL have port io_commit_pc  in  64*COMMIT_W  per-slot PC, slot i at bits [64i+63:64i].
REQ-008 SHALL have port io_trap_code  in  64  exit code (a0 value) accompanying a trap commit.
REQ-009 SHALL have port io_wfi  in  1  core currently stalled in WFI.
REQ-010 SHALL have port enable  out  1  event-valid strobe to the trap-event sink.
REQ-011 SHALL have ports io_hasTrap 1, io_cycleCnt 64, io_instrCnt 64, io_hasWFI 1, io_code 64, io_pc 64, io_coreid 8, all out, all registered, sink payload.

Function
REQ-012 SHALL implement two states: RUN, HALTED; reset enters RUN.
REQ-013 In RUN, each rising edge SHALL increment cycle counter by 1; io_cycleCnt SHALL equal number of RUN edges since reset release.
REQ-014 In RUN, each edge SHALL add to instruction counter the count of valid slots up to and including the first valid trap slot (all valid slots if none); io_instrCnt shows the updated total.
REQ-015 Valid slots need not be contiguous; only slots with io_commit_valid=1 count.
REQ-016 io_commit_is_trap on a slot with io_commit_valid=0 SHALL be ignored.
REQ-017 Multiple valid trap slots in one cycle: lowest-index slot SHALL win; younger slots not counted.
REQ-018 Counters SHALL wrap modulo 2^64, no saturation, no flag.
REQ-019 In RUN, every edge SHALL load enable=1, io_hasWFI=io_wfi, io_coreid=COREID; latency from inputs to outputs exactly one cycle.
REQ-020 On an edge in RUN with a winning trap slot: io_hasTrap<=1, io_code<=io_trap_code, io_pc<=that slot's PC, enable<=1, state<=HALTED.
REQ-021 Without trap, io_hasTrap SHALL stay 0 and io_code/io_pc SHALL hold prior value (0 after reset).
REQ-022 In HALTED: enable<=0 on next edge; all other outputs and counters frozen; commit/wfi inputs ignored; exit only via reset.
REQ-023 Exactly one enable cycle SHALL carry io_hasTrap=1 per reset epoch.

Reset
REQ-024 reset assertion SHALL immediately (no clock) force state RUN, enable=0, io_hasTrap=0, io_hasWFI=0, io_cycleCnt=0, io_instrCnt=0, io_code=0, io_pc=0, io_coreid=COREID.
REQ-025 Reset asserted mid-RUN or in HALTED SHALL discard all history; first edge after release yields io_cycleCnt=1.
REQ-026 Commits presented on an edge while reset is high SHALL not be counted.

Verification
REQ-027 Release reset, 5 edges, valid=00 -> enable=1 from edge 1, io_cycleCnt=5, io_instrCnt=0, io_hasTrap=0.
REQ-028 Edges: valid=01, 11, 10 -> io_instrCnt 1, 3, 4 after respective edges, each one cycle after input.
REQ-029 valid=11, is_trap=01, pc0=0x8000_0010, code=0 -> next cycle hasTrap=1, io_pc=0x80000010, io_code=0, instrCnt +1; following cycle enable=0, values frozen for 10 edges.
REQ-030 valid=11, is_trap=11, pc1=0x8000_0014 -> io_pc=pc0, instrCnt +1; valid=10, is_trap=11 -> io_pc=0x80000014, instrCnt +1.
REQ-031 Preload counter near 2^64-1 via force, valid=11 -> io_instrCnt wraps to 1; io_wfi=1 -> io_hasWFI=1 next cycle.
REQ-032 Assert reset in HALTED between edges -> outputs zero immediately; release, 1 edge -> enable=1, io_cycleCnt=1, io_hasTrap=0.

Source files
------------

// File: rtl/trap_event_gen.sv
// ----------------------------------------------------------------------------
// trap_event_gen
//
// Turns the core's commit stream into one payload per clock for a trap-event
// sink. While RUN, the block counts cycles and retired instructions and sends
// a valid payload every cycle. The first retired simulation-halt trap
// captures the exit code and PC, sends one final payload with io_hasTrap=1,
// and moves the block to HALTED. In HALTED the payload stays frozen and
// enable drops. Only reset leaves HALTED.
//
// Parameters
//   COREID    8-bit hart id reported on io_coreid
//   COMMIT_W  commit slots per cycle (1..4), slot 0 is the oldest
//
// Ports
//   clock              sole clock, rising edge
//   reset              asynchronous, active-high reset
//   io_commit_valid    [COMMIT_W]     per-slot retire strobe
//   io_commit_is_trap  [COMMIT_W]     per-slot halt-trap flag (valid slots only)
//   io_commit_pc       [64*COMMIT_W]  per-slot PC, slot i at [64i+63:64i]
//   io_trap_code       [64]           exit code accompanying a trap commit
//   io_wfi             core stalled in WFI
//   enable             payload-valid strobe to the sink
//   io_hasTrap, io_cycleCnt, io_instrCnt, io_hasWFI, io_code, io_pc,
//   io_coreid          registered sink payload
// ----------------------------------------------------------------------------
module trap_event_gen #(
  parameter logic [7:0] COREID   = 8'd0,
  parameter int         COMMIT_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [COMMIT_W-1:0]   io_commit_valid,
  input  logic [COMMIT_W-1:0]   io_commit_is_trap,
  input  logic [64*COMMIT_W-1:0] io_commit_pc,
  input  logic [63:0]           io_trap_code,
  input  logic                  io_wfi,
  output logic                  enable,
  output logic                  io_hasTrap,
  output logic [63:0]           io_cycleCnt,
  output logic [63:0]           io_instrCnt,
  output logic                  io_hasWFI,
  output logic [63:0]           io_code,
  output logic [63:0]           io_pc,
  output logic [7:0]            io_coreid
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t      state_q, state_d;

  // Retired-instruction total. The output port is a plain copy of it.
  logic [63:0] instr_cnt_q;

  // Result of scanning this cycle's commit slots.
  logic        trap_hit;
  logic [2:0]  slot_cnt;
  logic [63:0] trap_pc;

  // Next values for the payload registers.
  logic        enable_d;
  logic        has_trap_d;
  logic        has_wfi_d;
  logic [63:0] cycle_cnt_d;
  logic [63:0] instr_cnt_d;
  logic [63:0] code_d;
  logic [63:0] pc_d;

  // Walk the slots from oldest to youngest. Each valid slot is counted until
  // the first valid trap slot, and that trap slot is counted too. Slots
  // younger than the trap never retire. A trap flag on an invalid slot has
  // no effect.
  // NOTE: combinational blocks use blocking '=' and give every variable a
  // default first, so nothing holds its value between evaluations (no latch).
  always_comb begin
    trap_hit = 1'b0;
    slot_cnt = 3'd0;
    trap_pc  = 64'd0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (io_commit_valid[i] && !trap_hit) begin
        slot_cnt = slot_cnt + 3'd1;
        if (io_commit_is_trap[i]) begin
          trap_hit = 1'b1;
          trap_pc  = io_commit_pc[i*64 +: 64];
        end
      end
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. HALTED is absorbing until reset.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && trap_hit) begin
      state_d = HALTED;
    end
  end

  // Output logic. In HALTED every field holds its value and only enable
  // drops. Counters wrap naturally at 2^64.
  always_comb begin
    enable_d    = 1'b0;
    has_trap_d  = io_hasTrap;
    has_wfi_d   = io_hasWFI;
    cycle_cnt_d = io_cycleCnt;
    instr_cnt_d = instr_cnt_q;
    code_d      = io_code;
    pc_d        = io_pc;
    if (state_q == RUN) begin
      enable_d    = 1'b1;
      has_wfi_d   = io_wfi;
      cycle_cnt_d = io_cycleCnt + 64'd1;
      instr_cnt_d = instr_cnt_q + {61'd0, slot_cnt};
      if (trap_hit) begin
        has_trap_d = 1'b1;
        code_d     = io_trap_code;
        pc_d       = trap_pc;
      end
    end
  end

  // Payload registers, so the sink sees inputs exactly one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable      <= 1'b0;
      io_hasTrap  <= 1'b0;
      io_hasWFI   <= 1'b0;
      io_cycleCnt <= 64'd0;
      instr_cnt_q <= 64'd0;
      io_code     <= 64'd0;
      io_pc       <= 64'd0;
      io_coreid   <= COREID;
    end else begin
      enable      <= enable_d;
      io_hasTrap  <= has_trap_d;
      io_hasWFI   <= has_wfi_d;
      io_cycleCnt <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
      io_code     <= code_d;
      io_pc       <= pc_d;
      io_coreid   <= COREID;
    end
  end

  assign io_instrCnt = instr_cnt_q;

endmodule
